axi_slave_mem: RTL

Memory-backed responder for the simplified AXI-style read/write channels driven by the system Master. It accepts read and write address transactions, serves incrementing bursts of 1–16 bytes from an internal byte array, and returns write responses. Read and write paths are independent FSMs that share one dual-port array, so a read burst and a write burst can run concurrently.

---
 rtl/axi_slave_mem_if.sv | 31 +++
 rtl/axi_slave_mem.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem_if.sv
// Bundle of the simplified AXI-style read/write channels between the system
// Master and the memory-backed responder.
interface axi_slave_mem_if;
  logic        ARVALID;
  logic [15:0] AR;
  logic        ARREADY;
  logic        RVALID;
  logic        RREADY;
  logic [8:0]  R_OUT;
  logic        RLAST;
  logic        AWVALID;
  logic [11:0] AW;
  logic        AWREADY;
  logic        WVALID;
  logic [7:0]  WDATA;
  logic        WLAST;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY;
  logic [4:0]  BRESP;

  modport slave (
    input  ARVALID, AR, RREADY, AWVALID, AW, WVALID, WDATA, WLAST, BREADY,
    output ARREADY, RVALID, R_OUT, RLAST, AWREADY, WREADY, BVALID, BRESP
  );

  modport master (
    output ARVALID, AR, RREADY, AWVALID, AW, WVALID, WDATA, WLAST, BREADY,
    input  ARREADY, RVALID, R_OUT, RLAST, AWREADY, WREADY, BVALID, BRESP
  );
endinterface

// File: rtl/axi_slave_mem.sv
// Memory-backed burst responder: independent read and write FSMs sharing one
// dual-port byte array. Define SLAVE_ERR_EN to flag beats with addr >= MEM_DEPTH.
module axi_slave_mem #(
  parameter int MEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  axi_slave_mem_if.slave  bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic       {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [7:0] mem [MEM_DEPTH];

  r_state_t   r_state_reg;
  logic [7:0] r_addr_reg;
  logic [3:0] r_len_reg;
  logic [3:0] r_beat_reg;
  logic       arready_reg;
  logic       rvalid_reg;
  logic       rlast_reg;
  logic [8:0] r_out_reg;

  w_state_t   w_state_reg;
  logic [7:0] w_addr_reg;
  logic [3:0] w_id_reg;
  logic [4:0] w_cnt_reg;
  logic       w_err_reg;
  logic       awready_reg;
  logic       wready_reg;
  logic       bvalid_reg;
  logic [4:0] bresp_reg;

  // Read data is fetched one edge ahead so each beat is presented from a register.
  logic [7:0] rd_addr_next;
  logic [7:0] rd_byte;
  logic       rd_err;

  always_comb begin
    rd_addr_next = (r_state_reg == R_IDLE) ? bus.AR[15:8] : r_addr_reg + 8'd1;
  end

  logic wr_fire;
  logic wr_over;
  logic wr_addr_err;
  logic wr_en;

`ifdef SLAVE_ERR_EN
  assign rd_err      = ({1'b0, rd_addr_next} >= 9'(MEM_DEPTH));
  assign rd_byte     = rd_err ? 8'h00 : mem[rd_addr_next[IDX_W-1:0]];
  assign wr_addr_err = ({1'b0, w_addr_reg} >= 9'(MEM_DEPTH));
`else
  assign rd_err      = 1'b0;
  assign rd_byte     = mem[rd_addr_next[IDX_W-1:0]];
  assign wr_addr_err = 1'b0;
`endif

  assign wr_fire = (w_state_reg == W_DATA) && bus.WVALID;
  assign wr_over = w_cnt_reg[4];
  assign wr_en   = wr_fire && !wr_over && !wr_addr_err;

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[w_addr_reg[IDX_W-1:0]] <= bus.WDATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_reg <= R_IDLE;
      r_addr_reg  <= 8'd0;
      r_len_reg   <= 4'd0;
      r_beat_reg  <= 4'd0;
      arready_reg <= 1'b1;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
      r_out_reg   <= 9'd0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (bus.ARVALID) begin
            r_addr_reg  <= bus.AR[15:8];
            r_len_reg   <= bus.AR[7:4];
            r_beat_reg  <= 4'd0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            rlast_reg   <= (bus.AR[7:4] == 4'd0);
            r_out_reg   <= {rd_byte, rd_err};
            r_state_reg <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.RREADY) begin
            if (rlast_reg) begin
              rvalid_reg  <= 1'b0;
              rlast_reg   <= 1'b0;
              r_out_reg   <= 9'd0;
              arready_reg <= 1'b1;
              r_state_reg <= R_IDLE;
            end else begin
              r_addr_reg <= rd_addr_next;
              r_beat_reg <= r_beat_reg + 4'd1;
              rlast_reg  <= ((r_beat_reg + 4'd1) == r_len_reg);
              r_out_reg  <= {rd_byte, rd_err};
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg <= W_IDLE;
      w_addr_reg  <= 8'd0;
      w_id_reg    <= 4'd0;
      w_cnt_reg   <= 5'd0;
      w_err_reg   <= 1'b0;
      awready_reg <= 1'b1;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= 5'd0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (bus.AWVALID) begin
            w_addr_reg  <= bus.AW[11:4];
            w_id_reg    <= bus.AW[3:0];
            w_cnt_reg   <= 5'd0;
            w_err_reg   <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b1;
            w_state_reg <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_fire) begin
            w_addr_reg <= w_addr_reg + 8'd1;
            // Counter saturates at 16; every later beat is dropped and flagged.
            if (!wr_over) begin
              w_cnt_reg <= w_cnt_reg + 5'd1;
            end
            if (wr_over || wr_addr_err) begin
              w_err_reg <= 1'b1;
            end
            if (bus.WLAST) begin
              wready_reg  <= 1'b0;
              bvalid_reg  <= 1'b1;
              bresp_reg   <= {w_id_reg, w_err_reg | wr_over | wr_addr_err};
              w_state_reg <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bus.BREADY) begin
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 5'd0;
            awready_reg <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  assign bus.ARREADY = arready_reg;
  assign bus.RVALID  = rvalid_reg;
  assign bus.RLAST   = rlast_reg;
  assign bus.R_OUT   = r_out_reg;
  assign bus.AWREADY = awready_reg;
  assign bus.WREADY  = wready_reg;
  assign bus.BVALID  = bvalid_reg;
  assign bus.BRESP   = bresp_reg;
endmodule
